reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised successor to the 4x8 datapath register file. DW-bit x NREG entries,
//  1 write port, 2 combinational read ports. Adds a sequenced post-reset clear sweep
//  with busy/write-drop status. Sits between decode (addresses) and ALU (operands).
// PARAMETERS
//  DW    8                 data width in bits
//  NREG  4                 number of registers (>=2; need not be a power of 2)
//  AW    $clog2(NREG)      address width (derived; do not override)
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  reset     in   1   synchronous, active-high; starts/restarts the clear sweep
//  wen       in   1   write enable
//  w_addr    in   AW  write address
//  dataIn    in   DW  write data
//  r_addr1   in   AW  read address, port 1
//  r_addr2   in   AW  read address, port 2
//  dataOut1  out  DW  read data, port 1 (combinational)
//  dataOut2  out  DW  read data, port 2 (combinational)
//  busy      out  1   clear sweep in progress; registered
//  wr_drop   out  1   1-cycle registered pulse: a write was rejected on the previous edge
// BEHAVIOUR
//  - One clock (clk). Reset synchronous, active-high, sampled only on posedge clk.
//  - FSM states: IDLE, CLEAR. Power-up state IDLE; contents undefined until first reset.
//  - Edge with reset=1: state<=CLEAR, clr_ptr<=0, wr_drop<=0, no array write. busy=1 after.
//  - CLEAR, reset=0: Core[clr_ptr]<=0, clr_ptr<=clr_ptr+1. The edge that clears entry
//    NREG-1 sets state<=IDLE. First usable edge: NREG edges after reset deasserts.
//  - busy = (state==CLEAR). Reset value 1. Reads return 0 on both ports while busy.
//  - IDLE: wen=1 and w_addr<NREG -> Core[w_addr]<=dataIn on that edge.
//  - Rejected write (wr_drop<=1 on that edge): wen=1 while state==CLEAR, or w_addr>=NREG.
//    wen=1 during reset: ignored, no wr_drop. Otherwise wr_drop<=0.
//  - Read with r_addrN>=NREG: dataOutN=0. Both ports may address the same entry.
//  - Reset mid-sweep: sweep restarts at entry 0; already-cleared entries stay 0.
//  - No arithmetic on data; widths pass unchanged. clr_ptr is AW bits, never wraps past NREG-1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: in IDLE, wen=1 with valid w_addr==r_addrN ->
//    dataOutN=dataIn in the same cycle (write-through forwarding). Bypass disabled while busy.
//  Not defined: dataOutN shows pre-write contents until after the write edge.
// TESTING
//  1 reset 1 cycle, NREG=4 -> busy=1 for 4 edges after deassert, then 0; all reads 0.
//  2 Write 8'hA5 to r2, 8'h3C to r3; read r2/r3 next cycle -> dataOut1=A5, dataOut2=3C.
//  3 wen=1 w_addr=1 during sweep -> r1 stays 0, wr_drop=1 for one cycle.
//  4 Reset on 2nd sweep edge -> sweep restarts; busy held for 4 more edges.
//  5 NREG=5: wen w_addr=7 -> no write, wr_drop=1; r_addr1=6 -> dataOut1=0.
//  6 Write 8'h77 to r0 with r_addr1=0 -> same cycle 77 if REGFILE_BYPASS_EN, old value else.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised DW x NREG register file: 1 write port, 2 combinational reads, post-reset clear sweep.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_param #(
   parameter int DW   = 8,
   parameter int NREG = 4,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wen,
   input  logic [AW-1:0] w_addr,
   input  logic [DW-1:0] dataIn,
   input  logic [AW-1:0] r_addr1,
   input  logic [AW-1:0] r_addr2,
   output logic [DW-1:0] dataOut1,
   output logic [DW-1:0] dataOut2,
   output logic          busy,
   output logic          wr_drop
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
   localparam logic [AW-1:0] LAST   = AW'(NREG - 1);

   state_t        state, state_nxt;
   logic [AW-1:0] clr_ptr, clr_ptr_nxt;
   logic          wr_drop_nxt;
   logic          core_we;
   logic [AW-1:0] core_wa;
   logic [DW-1:0] core_wd;
   logic [DW-1:0] core [NREG];
   logic          w_ok, r1_ok, r2_ok;

   assign w_ok  = ({1'b0, w_addr}  < NREG_W);
   assign r1_ok = ({1'b0, r_addr1} < NREG_W);
   assign r2_ok = ({1'b0, r_addr2} < NREG_W);
   assign busy  = (state == CLEAR);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         wr_drop <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
         wr_drop <= wr_drop_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      wr_drop_nxt = 1'b0;
      core_we     = 1'b0;
      core_wa     = w_addr;
      core_wd     = dataIn;
      unique case (state)
         CLEAR: begin
            core_we     = 1'b1;
            core_wa     = clr_ptr;
            core_wd     = '0;
            clr_ptr_nxt = clr_ptr + 1'b1;
            wr_drop_nxt = wen;
            if (clr_ptr == LAST) begin
               state_nxt   = IDLE;
               clr_ptr_nxt = '0;
            end
         end
         IDLE: begin
            if (wen) begin
               core_we     = w_ok;
               wr_drop_nxt = !w_ok;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset edges never touch the array; the sweep does the clearing.
   always_ff @(posedge clk) begin
      if (!reset && core_we) core[core_wa] <= core_wd;
   end

`ifdef REGFILE_BYPASS_EN
   logic byp_en;
   assign byp_en = !reset && !busy && wen && w_ok;
`endif

   always_comb begin
      dataOut1 = '0;
      dataOut2 = '0;
      if (!busy && r1_ok) dataOut1 = core[r_addr1];
      if (!busy && r2_ok) dataOut2 = core[r_addr2];
`ifdef REGFILE_BYPASS_EN
      if (byp_en && w_addr == r_addr1) dataOut1 = dataIn;
      if (byp_en && w_addr == r_addr2) dataOut2 = dataIn;
`endif
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised + directed bench for reg_file_param (NREG=5, DW=8) against a behavioural model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_reg_file_param;

   localparam int DW   = 8;
   localparam int NREG = 5;
   localparam int AW   = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wen = 1'b0;
   logic [AW-1:0] w_addr = '0;
   logic [DW-1:0] dataIn = '0;
   logic [AW-1:0] r_addr1 = '0;
   logic [AW-1:0] r_addr2 = '0;
   logic [DW-1:0] dataOut1, dataOut2;
   logic          busy, wr_drop;

   reg_file_param #(.DW(DW), .NREG(NREG)) dut (
      .clk(clk), .reset(reset), .wen(wen), .w_addr(w_addr),
      .dataIn(dataIn), .r_addr1(r_addr1), .r_addr2(r_addr2),
      .dataOut1(dataOut1), .dataOut2(dataOut2),
      .busy(busy), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: contents, sweep position, status
   logic [DW-1:0] m_mem [NREG];
   bit            m_init = 0;
   bit            m_busy = 0;
   int            m_ptr  = 0;
   bit            m_drop = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input int a, input bit rst,
      input bit we, input int wa, input logic [DW-1:0] wd);
      if (m_busy || a >= NREG) return '0;
`ifdef REGFILE_BYPASS_EN
      if (!rst && we && wa < NREG && wa == a) return wd;
`endif
      return m_mem[a];
   endfunction

   task automatic step(input bit rst, input bit we, input int wa,
                       input logic [DW-1:0] wd, input int ra1, input int ra2,
                       output logic [DW-1:0] pre1);
      @(negedge clk);
      reset   = rst;
      wen     = we;
      w_addr  = AW'(wa);
      dataIn  = wd;
      r_addr1 = AW'(ra1);
      r_addr2 = AW'(ra2);
      #1;
      pre1 = dataOut1;
      if (m_init) begin
         check("busy", {31'd0, busy}, {31'd0, m_busy});
         check("wr_drop", {31'd0, wr_drop}, {31'd0, m_drop});
         check("rd1", {24'd0, dataOut1}, {24'd0, exp_rd(ra1, rst, we, wa, wd)});
         check("rd2", {24'd0, dataOut2}, {24'd0, exp_rd(ra2, rst, we, wa, wd)});
      end
      @(posedge clk);
      if (rst) begin
         m_init = 1;
         m_busy = 1;
         m_ptr  = 0;
         m_drop = 0;
      end else if (m_busy) begin
         m_mem[m_ptr] = '0;
         m_ptr++;
         if (m_ptr == NREG) m_busy = 0;
         m_drop = we;
      end else begin
         m_drop = we && wa >= NREG;
         if (we && wa < NREG) m_mem[wa] = wd;
      end
   endtask

   logic [DW-1:0] p;
   int            cnt;

   initial begin
      // reset, count busy edges; attempt a write to r1 mid-sweep
      step(1, 0, 0, 8'h00, 0, 1, p);
      #1;
      cnt = 0;
      while (busy && cnt < 12) begin
         step(0, cnt == 1, 1, 8'hFF, cnt % 8, 1, p);
         #1;
         if (cnt == 1) check("t3_drop", {31'd0, wr_drop}, 32'd1);
         cnt++;
      end
      check("t1_busy_len", cnt, NREG);
      step(0, 0, 0, 8'h00, 1, 4, p);
      #1;
      check("t3_r1_zero", {24'd0, dataOut1}, 32'h0);
      check("t3_drop_clr", {31'd0, wr_drop}, 32'd0);

      // basic writes and dual read
      step(0, 1, 2, 8'hA5, 0, 0, p);
      step(0, 1, 3, 8'h3C, 0, 0, p);
      step(0, 0, 0, 8'h00, 2, 3, p);
      #1;
      check("t2_rd1", {24'd0, dataOut1}, 32'hA5);
      check("t2_rd2", {24'd0, dataOut2}, 32'h3C);

      // reset again on the 2nd sweep edge: full NREG-edge sweep follows
      step(1, 0, 0, 8'h00, 2, 3, p);
      step(0, 0, 0, 8'h00, 2, 3, p);
      step(1, 0, 0, 8'h00, 2, 3, p);
      #1;
      cnt = 0;
      while (busy && cnt < 12) begin
         step(0, 0, 0, 8'h00, 2, 3, p);
         #1;
         cnt++;
      end
      check("t4_busy_len", cnt, NREG);
      step(0, 0, 0, 8'h00, 2, 3, p);
      #1;
      check("t4_r2_zero", {24'd0, dataOut1}, 32'h0);

      // out-of-range write and read
      step(0, 1, 7, 8'h99, 6, 4, p);
      #1;
      check("t5_drop", {31'd0, wr_drop}, 32'd1);
      check("t5_rd_oor", {24'd0, dataOut1}, 32'h0);

      // forwarding vs pre-write contents
      step(0, 1, 0, 8'h11, 0, 0, p);
      step(0, 1, 0, 8'h77, 0, 1, p);
`ifdef REGFILE_BYPASS_EN
      check("t6_same_cycle", {24'd0, p}, 32'h77);
`else
      check("t6_same_cycle", {24'd0, p}, 32'h11);
`endif
      #1;
      check("t6_after", {24'd0, dataOut1}, 32'h77);

      // random traffic, including occasional resets and illegal addresses
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 7)), DW'($urandom),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), p);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
